// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, stage flushes, mul/div scoreboard,
// branch-mispredict redirect and drain-then-redirect trap sequencing.
module pipe_hazard_ctrl #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  TRAP_VEC = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic                id_rs1_en_i,
  input  logic                id_rs2_en_i,
  input  logic [4:0]          id_rs1_idx_i,
  input  logic [4:0]          id_rs2_idx_i,
  input  logic                id_is_long_i,
  input  logic                ex_valid_i,
  input  logic                ex_is_load_i,
  input  logic                ex_rd_wen_i,
  input  logic [4:0]          ex_rd_idx_i,
  input  logic                ex_long_start_i,
  input  logic                wb_long_done_i,
  input  logic                ex_bjp_valid_i,
  input  logic                ex_prdt_taken_i,
  input  logic                ex_bjp_taken_i,
  input  logic [PC_WIDTH-1:0] ex_bjp_target_i,
  input  logic [PC_WIDTH-1:0] ex_pc_i,
  input  logic                ex_excp_i,
  input  logic                lsu_outstanding_i,
  output logic                id_load_use_o,
  output logic                if_flush_o,
  output logic                id_flush_o,
  output logic                ex_flush_o,
  output logic                redirect_valid_o,
  output logic [PC_WIDTH-1:0] redirect_pc_o,
  output logic                long_busy_o,
  output logic [PC_WIDTH-1:0] epc_o,
  output logic                trap_busy_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                state_q, state_d;
  logic                  long_busy_q;
  logic [4:0]            long_rd_q;
  logic [PC_WIDTH-1:0]   epc_q;

  logic                  mispredict;
  logic                  trap;
  logic                  long_start;
  logic                  ex_hit;
  logic                  sb_hit;
  logic                  struct_hit;

  assign mispredict = ex_valid_i & ex_bjp_valid_i & (ex_prdt_taken_i != ex_bjp_taken_i);
  assign trap       = ex_valid_i & ex_excp_i;

  // Source-operand hazard terms against the EX load and the scoreboard entry
  always_comb begin
    ex_hit = ex_valid_i & ex_is_load_i & ex_rd_wen_i & (ex_rd_idx_i != 5'd0) &
             ((id_rs1_en_i & (id_rs1_idx_i == ex_rd_idx_i)) |
              (id_rs2_en_i & (id_rs2_idx_i == ex_rd_idx_i)));
    sb_hit = long_busy_q & (long_rd_q != 5'd0) &
             ((id_rs1_en_i & (id_rs1_idx_i == long_rd_q)) |
              (id_rs2_en_i & (id_rs2_idx_i == long_rd_q)));
    struct_hit = id_is_long_i & long_busy_q;
  end

  // Trap FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state, flushes and redirect; trap wins over mispredict in RUN
  always_comb begin
    state_d          = state_q;
    if_flush_o       = 1'b0;
    id_flush_o       = 1'b0;
    ex_flush_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    unique case (state_q)
      RUN: begin
        if (trap) begin
          if_flush_o = 1'b1;
          id_flush_o = 1'b1;
          ex_flush_o = 1'b1;
          state_d    = DRAIN;
        end else if (mispredict) begin
          if_flush_o       = 1'b1;
          id_flush_o       = 1'b1;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = ex_bjp_taken_i ? ex_bjp_target_i : (ex_pc_i + PC_STEP);
        end
      end
      DRAIN: begin
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
        ex_flush_o = 1'b1;
        if (!lsu_outstanding_i && !long_busy_q) state_d = REDIR;
      end
      REDIR: begin
        if_flush_o       = 1'b1;
        id_flush_o       = 1'b1;
        ex_flush_o       = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = TRAP_VEC;
        state_d          = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A flushed ID instruction must not also stall
  always_comb begin
    id_load_use_o = id_valid_i & (ex_hit | sb_hit | struct_hit) & ~id_flush_o;
  end

  assign long_start = ex_long_start_i & ex_valid_i & ~ex_flush_o;

  // Scoreboard: a start in the same cycle as a done keeps the entry occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      long_busy_q <= 1'b0;
      long_rd_q   <= '0;
    end else if (long_start) begin
      long_busy_q <= 1'b1;
      long_rd_q   <= ex_rd_idx_i;
    end else if (wb_long_done_i) begin
      long_busy_q <= 1'b0;
    end
  end

  // Exception PC captured when the trap is taken
  always_ff @(posedge clk) begin
    if (rst)                        epc_q <= '0;
    else if (state_q == RUN && trap) epc_q <= ex_pc_i;
  end

  assign long_busy_o = long_busy_q;
  assign epc_o       = epc_q;
  assign trap_busy_o = (state_q != RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus, per-cycle comparison against a
// behavioural model, plus literal expectations at key points.
module tb_pipe_hazard_ctrl;

  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i, id_rs1_en_i, id_rs2_en_i, id_is_long_i;
  logic [4:0]    id_rs1_idx_i, id_rs2_idx_i, ex_rd_idx_i;
  logic          ex_valid_i, ex_is_load_i, ex_rd_wen_i, ex_long_start_i, wb_long_done_i;
  logic          ex_bjp_valid_i, ex_prdt_taken_i, ex_bjp_taken_i, ex_excp_i, lsu_outstanding_i;
  logic [PW-1:0] ex_bjp_target_i, ex_pc_i;
  logic          id_load_use_o, if_flush_o, id_flush_o, ex_flush_o, redirect_valid_o;
  logic          long_busy_o, trap_busy_o;
  logic [PW-1:0] redirect_pc_o, epc_o;

  pipe_hazard_ctrl #(.PC_WIDTH(PW), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
    .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i), .id_is_long_i(id_is_long_i),
    .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i), .ex_rd_wen_i(ex_rd_wen_i),
    .ex_rd_idx_i(ex_rd_idx_i), .ex_long_start_i(ex_long_start_i), .wb_long_done_i(wb_long_done_i),
    .ex_bjp_valid_i(ex_bjp_valid_i), .ex_prdt_taken_i(ex_prdt_taken_i), .ex_bjp_taken_i(ex_bjp_taken_i),
    .ex_bjp_target_i(ex_bjp_target_i), .ex_pc_i(ex_pc_i), .ex_excp_i(ex_excp_i),
    .lsu_outstanding_i(lsu_outstanding_i),
    .id_load_use_o(id_load_use_o), .if_flush_o(if_flush_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .long_busy_o(long_busy_o), .epc_o(epc_o), .trap_busy_o(trap_busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: trap in progress (waiting for quiet LSU/mul-div), one-shot
  // trap redirect owed, scoreboard entry and captured exception PC.
  bit          m_draining = 1'b0;
  bit          m_redir_due = 1'b0;
  bit          m_busy = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_epc = '0;

  function automatic bit id_reads(input logic [4:0] idx);
    return (id_rs1_en_i && id_rs1_idx_i == idx) || (id_rs2_en_i && id_rs2_idx_i == idx);
  endfunction

  // Per-cycle comparison and model advance (inputs are stable until the next posedge)
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit running = !m_draining && !m_redir_due;
      automatic bit trap = ex_valid_i && ex_excp_i;
      automatic bit misp = ex_valid_i && ex_bjp_valid_i && (ex_prdt_taken_i != ex_bjp_taken_i);
      automatic bit e_exf = !running || trap;
      automatic bit e_idf = !running || trap || misp;
      automatic bit e_rv = m_redir_due || (running && misp && !trap);
      automatic logic [31:0] e_pc = 32'h0;
      automatic bit stall;
      if (m_redir_due) e_pc = 32'h100;
      else if (e_rv) e_pc = ex_bjp_taken_i ? ex_bjp_target_i : ex_pc_i + 32'd4;
      stall = id_valid_i && !e_idf &&
              ((ex_valid_i && ex_is_load_i && ex_rd_wen_i && ex_rd_idx_i != 0 && id_reads(ex_rd_idx_i)) ||
               (m_busy && m_rd != 0 && id_reads(m_rd)) ||
               (id_is_long_i && m_busy));
      chk("m_if_flush", {31'b0, if_flush_o}, {31'b0, e_idf});
      chk("m_id_flush", {31'b0, id_flush_o}, {31'b0, e_idf});
      chk("m_ex_flush", {31'b0, ex_flush_o}, {31'b0, e_exf});
      chk("m_redir_v", {31'b0, redirect_valid_o}, {31'b0, e_rv});
      chk("m_redir_pc", redirect_pc_o, e_pc);
      chk("m_load_use", {31'b0, id_load_use_o}, {31'b0, stall});
      chk("m_long_busy", {31'b0, long_busy_o}, {31'b0, m_busy});
      chk("m_trap_busy", {31'b0, trap_busy_o}, {31'b0, !running});
      chk("m_epc", epc_o, m_epc);
      if (rst) begin
        m_draining = 0; m_redir_due = 0; m_busy = 0; m_rd = '0; m_epc = '0;
      end else begin
        automatic bit was_busy = m_busy;
        if (ex_long_start_i && ex_valid_i && !e_exf) begin
          if (m_busy && !wb_long_done_i) begin
            bad++;
            $display("FAIL sb_protocol: start while busy at %0t", $time);
          end
          m_busy = 1; m_rd = ex_rd_idx_i;
        end else if (wb_long_done_i) m_busy = 0;
        if (m_redir_due) m_redir_due = 0;
        else if (m_draining) begin
          if (!lsu_outstanding_i && !was_busy) begin m_draining = 0; m_redir_due = 1; end
        end else if (trap) begin
          m_draining = 1; m_epc = ex_pc_i;
        end
      end
    end
  end

  task automatic clr();
    id_valid_i = 0; id_rs1_en_i = 0; id_rs2_en_i = 0; id_is_long_i = 0;
    id_rs1_idx_i = '0; id_rs2_idx_i = '0; ex_rd_idx_i = '0;
    ex_valid_i = 0; ex_is_load_i = 0; ex_rd_wen_i = 0; ex_long_start_i = 0; wb_long_done_i = 0;
    ex_bjp_valid_i = 0; ex_prdt_taken_i = 0; ex_bjp_taken_i = 0; ex_excp_i = 0;
    lsu_outstanding_i = 0; ex_bjp_target_i = '0; ex_pc_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1; clr();
    cyc(); chk_en = 1;
    cyc(); rst = 0;
    mid();
    chk("rst_flush", {29'b0, if_flush_o, id_flush_o, ex_flush_o}, 32'h0);
    chk("rst_redir", {31'b0, redirect_valid_o}, 32'h0);
    chk("rst_busy", {30'b0, long_busy_o, trap_busy_o}, 32'h0);
    chk("rst_epc", epc_o, 32'h0);

    // load-use against EX load
    cyc(); clr(); ex_valid_i = 1; ex_is_load_i = 1; ex_rd_wen_i = 1; ex_rd_idx_i = 5;
    id_valid_i = 1; id_rs2_en_i = 1; id_rs2_idx_i = 5; mid();
    chk("lu_hit", {31'b0, id_load_use_o}, 32'h1);
    cyc(); ex_valid_i = 0; mid();
    chk("lu_ex_inv", {31'b0, id_load_use_o}, 32'h0);
    cyc(); ex_valid_i = 1; ex_rd_idx_i = 0; id_rs2_idx_i = 0; mid();
    chk("lu_x0", {31'b0, id_load_use_o}, 32'h0);

    // mispredicts; the load-use condition is also present but ID is flushed
    cyc(); clr(); ex_valid_i = 1; ex_bjp_valid_i = 1; ex_prdt_taken_i = 1; ex_pc_i = 32'h1000;
    ex_is_load_i = 1; ex_rd_wen_i = 1; ex_rd_idx_i = 5; id_valid_i = 1; id_rs1_en_i = 1; id_rs1_idx_i = 5;
    mid();
    chk("mp_flush", {29'b0, if_flush_o, id_flush_o, ex_flush_o}, 32'h6);
    chk("mp_rv", {31'b0, redirect_valid_o}, 32'h1);
    chk("mp_pc_nt", redirect_pc_o, 32'h1004);
    chk("mp_lu_forced", {31'b0, id_load_use_o}, 32'h0);
    cyc(); clr(); ex_valid_i = 1; ex_bjp_valid_i = 1; ex_bjp_taken_i = 1;
    ex_bjp_target_i = 32'h2000; ex_pc_i = 32'h1000; mid();
    chk("mp_pc_t", redirect_pc_o, 32'h2000);
    cyc(); ex_prdt_taken_i = 1; mid();
    chk("mp_correct", {31'b0, redirect_valid_o}, 32'h0);

    // trap with LSU outstanding for three cycles
    cyc(); clr(); ex_valid_i = 1; ex_excp_i = 1; ex_pc_i = 32'h80; lsu_outstanding_i = 1; mid();
    chk("tr_flush", {29'b0, if_flush_o, id_flush_o, ex_flush_o}, 32'h7);
    chk("tr_rv", {31'b0, redirect_valid_o}, 32'h0);
    cyc(); clr(); lsu_outstanding_i = 1; mid();
    chk("tr_epc", epc_o, 32'h80);
    chk("tr_busy", {31'b0, trap_busy_o}, 32'h1);
    cyc(); clr(); lsu_outstanding_i = 1; mid();
    chk("tr_d2_rv", {31'b0, redirect_valid_o}, 32'h0);
    cyc(); clr(); mid();
    chk("tr_d3_rv", {31'b0, redirect_valid_o}, 32'h0);
    cyc(); clr(); mid();
    chk("tr_redir_v", {31'b0, redirect_valid_o}, 32'h1);
    chk("tr_redir_pc", redirect_pc_o, 32'h100);
    chk("tr_redir_fl", {29'b0, if_flush_o, id_flush_o, ex_flush_o}, 32'h7);
    cyc(); clr(); mid();
    chk("tr_run", {31'b0, trap_busy_o}, 32'h0);
    chk("tr_run_rv", {31'b0, redirect_valid_o}, 32'h0);

    // scoreboard
    cyc(); clr(); ex_valid_i = 1; ex_long_start_i = 1; ex_rd_idx_i = 7; mid();
    chk("sb_not_yet", {31'b0, long_busy_o}, 32'h0);
    cyc(); clr(); id_valid_i = 1; id_rs1_en_i = 1; id_rs1_idx_i = 7; mid();
    chk("sb_busy", {31'b0, long_busy_o}, 32'h1);
    chk("sb_stall", {31'b0, id_load_use_o}, 32'h1);
    cyc(); wb_long_done_i = 1; mid();
    chk("sb_stall_done", {31'b0, id_load_use_o}, 32'h1);
    cyc(); wb_long_done_i = 0; mid();
    chk("sb_release", {31'b0, id_load_use_o}, 32'h0);
    cyc(); clr(); ex_valid_i = 1; ex_long_start_i = 1; ex_rd_idx_i = 7; mid();
    cyc(); clr(); ex_valid_i = 1; ex_long_start_i = 1; ex_rd_idx_i = 9; wb_long_done_i = 1; mid();
    cyc(); clr(); id_valid_i = 1; id_rs1_en_i = 1; id_rs1_idx_i = 7; mid();
    chk("sb_sd_busy", {31'b0, long_busy_o}, 32'h1);
    chk("sb_old_rd", {31'b0, id_load_use_o}, 32'h0);
    cyc(); id_rs1_idx_i = 9; mid();
    chk("sb_new_rd", {31'b0, id_load_use_o}, 32'h1);
    cyc(); id_rs1_en_i = 0; id_is_long_i = 1; mid();
    chk("sb_struct", {31'b0, id_load_use_o}, 32'h1);
    cyc(); clr(); wb_long_done_i = 1; mid();
    cyc(); clr(); mid();
    chk("sb_clear", {31'b0, long_busy_o}, 32'h0);

    // trap and mispredict together
    cyc(); clr(); ex_valid_i = 1; ex_excp_i = 1; ex_bjp_valid_i = 1; ex_prdt_taken_i = 1;
    ex_pc_i = 32'h300; mid();
    chk("pr_rv", {31'b0, redirect_valid_o}, 32'h0);
    chk("pr_exf", {31'b0, ex_flush_o}, 32'h1);
    cyc(); clr(); mid();
    chk("pr_drain", {31'b0, trap_busy_o}, 32'h1);
    chk("pr_epc", epc_o, 32'h300);
    cyc(); clr(); mid();
    chk("pr_redir", redirect_pc_o, 32'h100);
    cyc(); clr(); mid();

    // reset while draining with the scoreboard occupied
    cyc(); clr(); ex_valid_i = 1; ex_long_start_i = 1; ex_rd_idx_i = 3; mid();
    cyc(); clr(); ex_valid_i = 1; ex_excp_i = 1; ex_pc_i = 32'h40; mid();
    cyc(); clr(); mid();
    chk("rd_drain", {30'b0, long_busy_o, trap_busy_o}, 32'h3);
    cyc(); clr(); mid();
    chk("rd_hold", {31'b0, redirect_valid_o}, 32'h0);
    cyc(); clr(); rst = 1; mid();
    cyc(); rst = 0; mid();
    chk("rd_tbusy", {31'b0, trap_busy_o}, 32'h0);
    chk("rd_lbusy", {31'b0, long_busy_o}, 32'h0);
    chk("rd_outs", {27'b0, if_flush_o, id_flush_o, ex_flush_o, redirect_valid_o, id_load_use_o}, 32'h0);
    chk("rd_epc", epc_o, 32'h0);
    cyc(); mid();
    chk("rd_no_redir", {31'b0, redirect_valid_o}, 32'h0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: run did not complete, expected finish before %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
